bidir_shift_reg: RTL and testbench

//  - Serial-in / parallel-out bidirectional shift register. Width is parameterised; default is 4 bits.
//  - Each clock, the register shifts one position left or right, as selected by shift_left.
//  - serial_in fills the vacated end; the full register contents are driven on data_out.
//  - Used as a generic datapath building block for serial-to-parallel conversion and bit-pattern generation.

---
 rtl/bidir_shift_reg_if.sv | 22 ++
 rtl/bidir_shift_reg.sv | 26 ++
 tb/tb_bidir_shift_reg.sv | 124 ++++++++++++
 3 files changed

// File: rtl/bidir_shift_reg_if.sv
// Port bundle for bidir_shift_reg: direction/serial controls in, parallel word out.
// No valid/ready handshake: every rising clk edge is a transfer. The master holds shift_left and
// serial_in stable around the edge, and data_out is valid from just after the edge until the next one.
interface bidir_shift_reg_if #(
  parameter int WIDTH = 4
);
  logic             shift_left;
  logic             serial_in;
  logic [WIDTH-1:0] data_out;

  modport master (
    output shift_left,
    output serial_in,
    input  data_out
  );

  modport slave (
    input  shift_left,
    input  serial_in,
    output data_out
  );
endinterface

// File: rtl/bidir_shift_reg.sv
// Serial-in / parallel-out bidirectional shift register; shifts one place per clock in the
// direction selected by shift_left, with serial_in filling the vacated end.
module bidir_shift_reg #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  bidir_shift_reg_if.slave   bus
);

  logic [WIDTH-1:0] shreg;

  // Reset takes priority; otherwise the register always shifts, as there is no hold state.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg <= '0;
    end else if (bus.shift_left) begin
      shreg <= {shreg[WIDTH-2:0], bus.serial_in};
    end else begin
      shreg <= {bus.serial_in, shreg[WIDTH-1:1]};
    end
  end

  assign bus.data_out = shreg;

endmodule

// File: tb/tb_bidir_shift_reg.sv
// Scoreboard bench for bidir_shift_reg: directed sequence plus randomized shifts, checked
// against an arithmetic model (multiply/divide by two with modular wrap).
module tb_bidir_shift_reg;
  localparam int W = 4;

  logic clk;
  logic rst;

  bidir_shift_reg_if #(.WIDTH(W)) bus ();

  bidir_shift_reg #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock and reset.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int unsigned  model;
  int           checks;
  int           failures;
  logic         timed_out;

  // Reference: left shift is m*2+si mod 2^W, right shift is m/2 + si*2^(W-1).
  function automatic int unsigned model_next(int unsigned m, bit r, bit sl, bit si);
    int unsigned full;
    full = 1 << W;
    if (r) return 0;
    if (sl) return (m * 2 + si) % full;
    return m / 2 + (si ? full / 2 : 0);
  endfunction

  // Driver: inputs change at the falling edge; optional glitches on rst/serial_in between edges.
  // exp_v >= 0 supplies a hand-written expected word; otherwise the model value is used.
  task automatic drive(input bit r, input bit sl, input bit si, input bit glitch,
                       input int exp_v, input string nm);
    @(negedge clk);
    bus.shift_left = sl;
    bus.serial_in  = si;
    if (glitch) begin
      #1 rst = ~r;
      bus.serial_in = ~si;
      #1;
    end
    rst           = r;
    bus.serial_in = si;
    @(posedge clk);
    #1;
    model = model_next(model, r, sl, si);
    if (exp_v >= 0) exp_q.push_back(W'(exp_v));
    else            exp_q.push_back(W'(model));
    name_q.push_back(nm);
  endtask

  // Monitor: data_out is presented for the whole low phase; compare at the falling edge.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      logic [W-1:0] e;
      string        n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      checks++;
      if (bus.data_out !== e) begin
        failures++;
        $display("FAIL %s: data_out=%b expected=%b at %0t", n, bus.data_out, e, $time);
      end
    end
  end

  initial begin
    checks    = 0;
    failures  = 0;
    timed_out = 1'b0;
    model     = 0;
    rst           = 1'b0;
    bus.shift_left = 1'b0;
    bus.serial_in  = 1'b0;

    drive(1, 0, 0, 0, 'b0000, "reset");
    drive(0, 0, 0, 0, 'b0000, "right_zero");
    drive(0, 0, 1, 0, 'b1000, "right_fill1");
    drive(0, 0, 1, 0, 'b1100, "right_fill2");
    drive(0, 1, 0, 0, 'b1000, "left_flush1");
    drive(0, 1, 0, 0, 'b0000, "left_flush2");
    drive(0, 1, 1, 0, 'b0001, "left_fill1");
    drive(0, 1, 1, 0, 'b0011, "left_fill2");
    drive(0, 1, 1, 0, 'b0111, "overflow1");
    drive(0, 1, 1, 0, 'b1111, "overflow2");
    drive(0, 1, 1, 0, 'b1111, "overflow3");
    drive(0, 1, 1, 0, 'b1111, "overflow4");
    drive(1, 1, 1, 0, 'b0000, "reset_wins");
    drive(0, 0, 0, 0, 'b0000, "load0");
    drive(0, 0, 1, 0, 'b1000, "load1");
    drive(0, 0, 0, 0, 'b0100, "load2");
    drive(0, 0, 1, 0, 'b1010, "load3");
    drive(0, 1, 0, 0, 'b0100, "toggle_left");
    drive(0, 0, 1, 0, 'b1010, "toggle_right");
    // Mid-cycle pulses on rst and serial_in must not disturb the register.
    drive(0, 0, 1, 1, 'b1101, "glitch1");
    drive(0, 1, 0, 1, 'b1010, "glitch2");
    drive(0, 1, 1, 1, 'b0101, "glitch3");

    for (int i = 0; i < 300; i++) begin
      drive(($urandom_range(0, 15) == 0), $urandom_range(0, 1), $urandom_range(0, 1),
            ($urandom_range(0, 7) == 0), -1, "random");
    end

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      timed_out = 1'b1;
      $display("FAIL drain_timeout: pending=%0d expected=0", exp_q.size());
    end
    @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + (timed_out ? 1 : 0));
    $finish;
  end

endmodule
